// File: rtl/m6800_peripheral_target_if.sv
// E/VMA bus and port pins between the bus emulation and the peripheral target.
// The master modport drives the CPU side of the bus and the port input pins.
interface m6800_peripheral_target_if;
    logic       E;
    logic       VMA_n;
    logic       CS_n;
    logic       RW;
    logic [2:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic [7:0] PA_IN;
    logic [7:0] PA_OUT;
    logic [7:0] PA_DDR;
    logic       IRQ_n;

    modport master (
        output E, VMA_n, CS_n, RW, ADDR, DATA_IN, PA_IN,
        input  DATA_OUT, DATA_OE, PA_OUT, PA_DDR, IRQ_n
    );

    modport slave (
        input  E, VMA_n, CS_n, RW, ADDR, DATA_IN, PA_IN,
        output DATA_OUT, DATA_OE, PA_OUT, PA_DDR, IRQ_n
    );
endinterface

// File: rtl/m6800_peripheral_target.sv
// 6800-style E/VMA bus responder exposing a CIA-lite register set:
// one 8-bit I/O port, a 16-bit E-rate down-counter timer and an interrupt control register.
module m6800_peripheral_target #(
    parameter logic [15:0] TIMER_LATCH_INIT = 16'hFFFF,
    parameter logic [7:0]  PORT_INIT        = 8'h00
) (
    input  logic                          C7M,
    input  logic                          RESET,
    m6800_peripheral_target_if.slave      bus
);
    localparam logic [2:0] A_PRA  = 3'd0;
    localparam logic [2:0] A_DDRA = 3'd1;
    localparam logic [2:0] A_TALO = 3'd2;
    localparam logic [2:0] A_TAHI = 3'd3;
    localparam logic [2:0] A_CRA  = 3'd4;
    localparam logic [2:0] A_ICR  = 3'd5;

    logic        e_d;
    logic        sel;
    logic        rw_q;
    logic [2:0]  addr_q;
    logic [15:0] latch;
    logic [15:0] counter;
    logic        start;
    logic        oneshot;
    logic        ta_flag;
    logic        mask0;
    logic [7:0]  rd_mux;

    wire rise      = bus.E & ~e_d;
    wire fall      = ~bus.E & e_d;
    wire qual      = ~bus.VMA_n & ~bus.CS_n;
    wire wr_done   = fall & sel & ~rw_q;
    wire rd_done   = fall & sel & rw_q;
    wire tick      = fall & start;
    wire underflow = tick & (counter == 16'd0);
    wire irq       = ta_flag & mask0;

    // Read data is captured at rise, so a same-tick underflow never shows in it.
    always_comb begin
        rd_mux = 8'h00;
        case (bus.ADDR)
            A_PRA:   rd_mux = (bus.PA_IN & ~bus.PA_DDR) | (bus.PA_OUT & bus.PA_DDR);
            A_DDRA:  rd_mux = bus.PA_DDR;
            A_TALO:  rd_mux = counter[7:0];
            A_TAHI:  rd_mux = counter[15:8];
            A_CRA:   rd_mux = {4'b0000, oneshot, 2'b00, start};
            A_ICR:   rd_mux = {irq, 6'b000000, ta_flag};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            e_d          <= 1'b0;
            sel          <= 1'b0;
            rw_q         <= 1'b1;
            addr_q       <= 3'd0;
            latch        <= TIMER_LATCH_INIT;
            counter      <= TIMER_LATCH_INIT;
            start        <= 1'b0;
            oneshot      <= 1'b0;
            ta_flag      <= 1'b0;
            mask0        <= 1'b0;
            bus.DATA_OUT <= 8'h00;
            bus.DATA_OE  <= 1'b0;
            bus.PA_OUT   <= PORT_INIT;
            bus.PA_DDR   <= 8'h00;
            bus.IRQ_n    <= 1'b1;
        end else begin
            e_d <= bus.E;

            if (rise) begin
                sel    <= qual;
                addr_q <= bus.ADDR;
                rw_q   <= bus.RW;
                if (qual && bus.RW) begin
                    bus.DATA_OUT <= rd_mux;
                    bus.DATA_OE  <= 1'b1;
                end
            end else if (fall) begin
                sel         <= 1'b0;
                bus.DATA_OE <= 1'b0;
            end

            if (tick) begin
                if (counter != 16'd0) begin
                    counter <= counter - 16'd1;
                end else begin
                    counter <= latch;
                    if (oneshot) start <= 1'b0;
                end
            end

            // Underflow set is ordered after the read clear so the set wins.
            if (rd_done && addr_q == A_ICR) ta_flag <= 1'b0;
            if (underflow) ta_flag <= 1'b1;

            // Register writes come last so a write load overrides the underflow reload.
            if (wr_done) begin
                case (addr_q)
                    A_PRA:  bus.PA_OUT <= bus.DATA_IN;
                    A_DDRA: bus.PA_DDR <= bus.DATA_IN;
                    A_TALO: latch[7:0] <= bus.DATA_IN;
                    A_TAHI: begin
                        latch[15:8] <= bus.DATA_IN;
                        if (!start) counter <= {bus.DATA_IN, latch[7:0]};
                    end
                    A_CRA: begin
                        start   <= bus.DATA_IN[0];
                        oneshot <= bus.DATA_IN[3];
                        if (bus.DATA_IN[4]) counter <= latch;
                    end
                    A_ICR: if (bus.DATA_IN[0]) mask0 <= bus.DATA_IN[7];
                    default: ;
                endcase
            end

            bus.IRQ_n <= ~irq;
        end
    end
endmodule

// File: tb/tb_m6800_peripheral_target.sv
// Directed vector bench for the 6800 peripheral target: a table of bus cycles with
// hand-computed results, plus reset-during-access sequences.
module tb_m6800_peripheral_target;
    localparam logic [2:0] PRA = 3'd0, DDRA = 3'd1, TALO = 3'd2, TAHI = 3'd3,
                           CRA = 3'd4, ICR = 3'd5;
    localparam logic R = 1'b1, W = 1'b0;

    typedef struct {
        logic       rw;
        logic [2:0] a;
        logic [7:0] d;
        logic       vma_n;
        logic       cs_n;
        logic [7:0] pa_in;
        logic [7:0] exp_rd;
        int         exp_oe;
        logic [7:0] exp_pa_out;
        logic [7:0] exp_ddr;
        logic       exp_irq_n;
    } vec_t;

    logic C7M;
    logic RESET;
    m6800_peripheral_target_if bus_if();

    m6800_peripheral_target #(.TIMER_LATCH_INIT(16'hFFFF), .PORT_INIT(8'h00)) dut (
        .C7M  (C7M),
        .RESET(RESET),
        .bus  (bus_if)
    );

    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    int         oe_total = 0;
    logic [7:0] rd_cap = 8'h00;
    always @(negedge C7M) begin
        if (bus_if.DATA_OE === 1'b1) begin
            oe_total <= oe_total + 1;
            rd_cap   <= bus_if.DATA_OUT;
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vt[$];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rw, input logic [2:0] a, input logic [7:0] d,
                       input logic vma_n, input logic cs_n, input logic [7:0] exp_rd,
                       input int exp_oe, input logic [7:0] exp_pa_out,
                       input logic [7:0] exp_ddr, input logic exp_irq_n);
        vec_t v;
        v.rw = rw; v.a = a; v.d = d; v.vma_n = vma_n; v.cs_n = cs_n; v.pa_in = 8'h3C;
        v.exp_rd = exp_rd; v.exp_oe = exp_oe; v.exp_pa_out = exp_pa_out;
        v.exp_ddr = exp_ddr; v.exp_irq_n = exp_irq_n;
        vt.push_back(v);
    endtask

    // One E period: 4 clocks high, 3 clocks low; address/data held across the fall.
    task automatic bus_cycle(input vec_t v, output int oe_n);
        int base;
        @(posedge C7M); #1;
        base = oe_total;
        bus_if.RW = v.rw; bus_if.ADDR = v.a; bus_if.DATA_IN = v.d;
        bus_if.VMA_n = v.vma_n; bus_if.CS_n = v.cs_n; bus_if.PA_IN = v.pa_in;
        bus_if.E = 1'b1;
        repeat (4) begin @(posedge C7M); #1; end
        bus_if.E = 1'b0;
        repeat (3) begin @(posedge C7M); #1; end
        bus_if.VMA_n = 1'b1; bus_if.CS_n = 1'b1;
        oe_n = oe_total - base;
    endtask

    task automatic reset_mid(input int idx, input logic rw, input logic [2:0] a, input logic [7:0] d);
        @(posedge C7M); #1;
        bus_if.RW = rw; bus_if.ADDR = a; bus_if.DATA_IN = d;
        bus_if.VMA_n = 1'b0; bus_if.CS_n = 1'b0; bus_if.E = 1'b1;
        repeat (2) begin @(posedge C7M); #1; end
        if (rw) chk("oe_before_reset", idx, {15'd0, bus_if.DATA_OE}, 16'd1);
        RESET = 1'b1; bus_if.VMA_n = 1'b1; bus_if.CS_n = 1'b1;
        @(posedge C7M); #1;
        RESET = 1'b0;
        chk("oe_drop_on_reset", idx, {15'd0, bus_if.DATA_OE}, 16'd0);
        @(posedge C7M); #1;
        bus_if.E = 1'b0;
        repeat (3) begin @(posedge C7M); #1; end
        chk("rst_pa_ddr",   idx, {8'd0, bus_if.PA_DDR},   16'h0000);
        chk("rst_pa_out",   idx, {8'd0, bus_if.PA_OUT},   16'h0000);
        chk("rst_data_out", idx, {8'd0, bus_if.DATA_OUT}, 16'h0000);
        chk("rst_data_oe",  idx, {15'd0, bus_if.DATA_OE}, 16'd0);
        chk("rst_irq_n",    idx, {15'd0, bus_if.IRQ_n},   16'd1);
    endtask

    initial begin
        int oe_n;
        //  rw  addr  din    vma cs   rd     oe pa_out ddr    irq_n
        add(R, DDRA, 8'h00, 0, 0, 8'h00, 4, 8'h00, 8'h00, 1);
        add(R, ICR,  8'h00, 0, 0, 8'h00, 4, 8'h00, 8'h00, 1);
        add(W, DDRA, 8'hF0, 0, 0, 8'h00, 0, 8'h00, 8'hF0, 1);
        add(W, PRA,  8'hA5, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);
        add(R, PRA,  8'h00, 0, 0, 8'hAC, 4, 8'hA5, 8'hF0, 1);
        add(W, PRA,  8'hFF, 1, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);  // VMA_n high: ignored
        add(R, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 1);  // not selected
        add(R, 3'd6, 8'h00, 0, 0, 8'h00, 4, 8'hA5, 8'hF0, 1);
        add(W, 3'd7, 8'hFF, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);
        add(W, TALO, 8'h03, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);
        add(W, TAHI, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);
        add(R, TALO, 8'h00, 0, 0, 8'h03, 4, 8'hA5, 8'hF0, 1);
        add(R, TAHI, 8'h00, 0, 0, 8'h00, 4, 8'hA5, 8'hF0, 1);
        add(W, CRA,  8'h09, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);  // one-shot start
        add(W, ICR,  8'h81, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);  // tick 1
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 1);  // tick 2
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 1);  // tick 3
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 0);  // tick 4: underflow
        add(R, CRA,  8'h00, 0, 0, 8'h08, 4, 8'hA5, 8'hF0, 0);
        add(R, TALO, 8'h00, 0, 0, 8'h03, 4, 8'hA5, 8'hF0, 0);
        add(R, TAHI, 8'h00, 0, 0, 8'h00, 4, 8'hA5, 8'hF0, 0);
        add(W, TALO, 8'h01, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 0);
        add(W, TAHI, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 0);
        add(R, ICR,  8'h00, 0, 0, 8'h81, 4, 8'hA5, 8'hF0, 1);  // read clears flag
        add(R, ICR,  8'h00, 0, 0, 8'h00, 4, 8'hA5, 8'hF0, 1);
        add(W, CRA,  8'h01, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);  // continuous start
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 1);  // 1 -> 0
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 0);  // underflow
        add(R, ICR,  8'h00, 0, 0, 8'h81, 4, 8'hA5, 8'hF0, 1);
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 0);
        add(R, ICR,  8'h00, 0, 0, 8'h81, 4, 8'hA5, 8'hF0, 1);
        add(R, ICR,  8'h00, 0, 0, 8'h00, 4, 8'hA5, 8'hF0, 0);  // clear vs set: set wins
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 0);
        add(R, ICR,  8'h00, 0, 0, 8'h81, 4, 8'hA5, 8'hF0, 0);  // clear vs set, flag held
        add(R, ICR,  8'h00, 0, 0, 8'h81, 4, 8'hA5, 8'hF0, 1);
        add(W, CRA,  8'h00, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 0);  // stop on underflow tick
        add(R, CRA,  8'h00, 0, 0, 8'h00, 4, 8'hA5, 8'hF0, 0);
        add(R, TALO, 8'h00, 0, 0, 8'h01, 4, 8'hA5, 8'hF0, 0);
        add(W, PRA,  8'h00, 0, 1, 8'h00, 0, 8'hA5, 8'hF0, 0);
        add(W, ICR,  8'h01, 0, 0, 8'h00, 0, 8'hA5, 8'hF0, 1);  // clear MASK0
        add(R, ICR,  8'h00, 0, 0, 8'h01, 4, 8'hA5, 8'hF0, 1);

        RESET = 1'b1;
        bus_if.E = 1'b0; bus_if.VMA_n = 1'b1; bus_if.CS_n = 1'b1; bus_if.RW = 1'b1;
        bus_if.ADDR = 3'd0; bus_if.DATA_IN = 8'h00; bus_if.PA_IN = 8'h3C;
        repeat (3) @(posedge C7M);
        #1;
        RESET = 1'b0;
        chk("reset_data_out", -1, {8'd0, bus_if.DATA_OUT}, 16'h0000);
        chk("reset_data_oe",  -1, {15'd0, bus_if.DATA_OE}, 16'd0);
        chk("reset_pa_out",   -1, {8'd0, bus_if.PA_OUT},   16'h0000);
        chk("reset_pa_ddr",   -1, {8'd0, bus_if.PA_DDR},   16'h0000);
        chk("reset_irq_n",    -1, {15'd0, bus_if.IRQ_n},   16'd1);

        for (int i = 0; i < vt.size(); i++) begin
            bus_cycle(vt[i], oe_n);
            chk("data_oe_clocks", i, oe_n[15:0], vt[i].exp_oe[15:0]);
            if (vt[i].exp_oe > 0) begin
                chk("read_data", i, {8'd0, rd_cap},          {8'd0, vt[i].exp_rd});
                chk("data_held", i, {8'd0, bus_if.DATA_OUT}, {8'd0, vt[i].exp_rd});
            end
            chk("pa_out", i, {8'd0, bus_if.PA_OUT},  {8'd0, vt[i].exp_pa_out});
            chk("pa_ddr", i, {8'd0, bus_if.PA_DDR},  {8'd0, vt[i].exp_ddr});
            chk("irq_n",  i, {15'd0, bus_if.IRQ_n},  {15'd0, vt[i].exp_irq_n});
        end

        reset_mid(100, R, PRA,  8'h00);
        reset_mid(101, W, DDRA, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
